// File: rtl/rr_arb_pkg.sv
// Shared widths and the channel-index type for the 4-channel round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned CH_N  = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_prio_4.sv
// Rotating priority search: first requester after 'last' in round-robin order.
module rr_prio_4
  import rr_arb_pkg::*;
(
  input  logic [CH_N-1:0] req,
  input  sel_t            last,
  output logic            any,
  output sel_t            g
);

  sel_t idx;

  // Walk from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    any = 1'b0;
    g   = last;
    idx = last;
    for (int k = CH_N; k > 0; k--) begin
      idx = last + sel_t'(k);
      if (req[idx]) begin
        any = 1'b1;
        g   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_arb_4.sv
// Four-channel round-robin arbiter with valid/ready handshakes and a
// one-entry registered output carrying the winning word and its index.
module rr_arb_4
  import rr_arb_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH_N-1:0] in_valid,
  input  logic [W-1:0]    in_data0,
  input  logic [W-1:0]    in_data1,
  input  logic [W-1:0]    in_data2,
  input  logic [W-1:0]    in_data3,
  output logic [CH_N-1:0] in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output sel_t            out_sel,
  input  logic            out_ready
);

  sel_t         last;
  sel_t         g;
  logic         any;
  logic         load;
  logic         grant;
  logic [W-1:0] win_data;

  rr_prio_4 u_prio (
    .req  (in_valid),
    .last (last),
    .any  (any),
    .g    (g)
  );

  assign load  = !out_valid || out_ready;
  assign grant = rst_n && load && any;

  // Handshake never depends on payload; reset blocks any acceptance.
  assign in_ready = grant ? (CH_N'(1) << g) : '0;

  always_comb begin
    win_data = in_data0;
    unique case (g)
      2'd0:    win_data = in_data0;
      2'd1:    win_data = in_data1;
      2'd2:    win_data = in_data2;
      default: win_data = in_data3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= sel_t'(CH_N - 1);
    end else if (load) begin
      out_valid <= any;
      if (any) begin
        out_data <= win_data;
        out_sel  <= g;
        last     <= g;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_4.sv
// Scoreboard bench for rr_arb_4: directed scenarios then randomised traffic.
module tb_rr_arb_4;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] data;
  } word_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_valid;
  logic [3:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready;

  int    n_checks = 0;
  int    n_pass   = 0;
  word_t sb_q[$];
  logic  m_ov     = 1'b0;
  logic [1:0] m_last = 2'd3;
  logic [3:0] dat[4];
  int    wait_cnt[4];

  always #5 clk = ~clk;

  rr_arb_4 #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [1:0] model_pick(input logic [1:0] l, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (int'(l) + k) % 4;
      if (v[i]) return 2'(i);
    end
    return l;
  endfunction

  // One cycle: drive at negedge, check registers and in_ready, update model.
  task automatic step(input logic [3:0] v, input logic r, input logic rst);
    logic [3:0] exp_rdy;
    logic [1:0] g;
    word_t      w;
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    rst_n     = rst;
    in_data0  = dat[0];
    in_data1  = dat[1];
    in_data2  = dat[2];
    in_data3  = dat[3];
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        check("out_data", 32'(out_data), 32'(sb_q[0].data));
        check("out_sel", 32'(out_sel), 32'(sb_q[0].sel));
      end
    end
    check("onehot0", 32'($onehot0(in_ready)), 32'd1);
    exp_rdy = 4'b0000;
    if (!rst) begin
      sb_q.delete();
      m_ov   = 1'b0;
      m_last = 2'd3;
      for (int c = 0; c < 4; c++) wait_cnt[c] = 0;
    end else begin
      logic load;
      load = !m_ov || r;
      if (m_ov && r && sb_q.size() != 0) void'(sb_q.pop_front());
      if (load && (v != 4'b0000)) begin
        g          = model_pick(m_last, v);
        exp_rdy[g] = 1'b1;
        w.sel      = g;
        w.data     = dat[g];
        sb_q.push_back(w);
        m_last     = g;
        m_ov       = 1'b1;
        for (int c = 0; c < 4; c++) begin
          if (c == int'(g)) wait_cnt[c] = 0;
          else if (v[c]) begin
            wait_cnt[c]++;
            check("fairness", 32'(wait_cnt[c] <= 3), 32'd1);
          end else wait_cnt[c] = 0;
        end
      end else begin
        if (load) m_ov = 1'b0;
        for (int c = 0; c < 4; c++) if (!v[c]) wait_cnt[c] = 0;
      end
    end
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      dat[c] = 4'h0;
      wait_cnt[c] = 0;
    end
    rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    in_data0 = 4'h0; in_data1 = 4'h0; in_data2 = 4'h0; in_data3 = 4'h0;
    repeat (2) @(posedge clk);
    step(4'hF, 1'b1, 1'b0);
    check("rst_ready", 32'(in_ready), 32'd0);

    // All channels request with fixed payloads: grants rotate 0,1,2,3,0.
    dat[0] = 4'hA; dat[1] = 4'hB; dat[2] = 4'hC; dat[3] = 4'hD;
    for (int k = 0; k < 5; k++) begin
      step(4'hF, 1'b1, 1'b1);
      check("rot_grant", 32'(in_ready), 32'(4'b0001 << (k % 4)));
    end
    step(4'h0, 1'b1, 1'b1);

    // last = 1, then ch0 and ch1 request: ch0 first, then ch1.
    step(4'b0010, 1'b1, 1'b1);
    step(4'b0011, 1'b1, 1'b1);
    check("after1_ch0", 32'(in_ready), 32'b0001);
    step(4'b0011, 1'b1, 1'b1);
    check("then_ch1", 32'(in_ready), 32'b0010);

    // Backpressure: word 5 holds for three cycles, ch2 waits.
    dat[1] = 4'h5; dat[2] = 4'h7;
    step(4'b0010, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(4'b0100, 1'b0, 1'b1);
      check("hold_data", 32'(out_data), 32'h5);
      check("hold_ready", 32'(in_ready), 32'h0);
    end
    step(4'b0100, 1'b1, 1'b1);
    check("bp_release", 32'(in_ready), 32'b0100);

    // Idle drains the output, then a lone ch3 request wins at once.
    step(4'h0, 1'b1, 1'b1);
    step(4'h0, 1'b1, 1'b1);
    check("idle_valid", 32'(out_valid), 32'd0);
    step(4'b1000, 1'b1, 1'b1);
    check("ch3_ready", 32'(in_ready), 32'b1000);
    step(4'h0, 1'b1, 1'b1);
    check("ch3_sel", 32'(out_sel), 32'd3);

    // Reset with a held word and all channels requesting.
    step(4'hF, 1'b1, 1'b1);
    step(4'hF, 1'b1, 1'b1);
    step(4'hF, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_sel", 32'(out_sel), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    step(4'hF, 1'b1, 1'b1);
    check("post_rst_ch0", 32'(in_ready), 32'b0001);

    // Random traffic against the scoreboard.
    for (int n = 0; n < 1000; n++) begin
      for (int c = 0; c < 4; c++) dat[c] = 4'($urandom);
      step(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'b1);
    end
    for (int n = 0; n < 3; n++) step(4'h0, 1'b1, 1'b1);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
